// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect handling.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_en_o,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
);

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_advance;
    logic        w_unused_align;

    // Targets are word aligned; the low address bits are discarded.
    assign w_redirect_pc  = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_align = ^redirect_pc_i[1:0];
    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_advance      = ~redirect_i & ~stall_i;

    assign imem_addr_o   = r_pc;
    assign imem_en_o     = rst_n & (~stall_i | redirect_i);
    assign id_valid_o    = r_id_valid;
    assign id_instr_o    = r_id_instr;
    assign id_pc_o       = r_id_pc;
    assign id_pc_plus4_o = r_id_pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
        end else if (redirect_i) begin
            // Flush squashes only the instruction; the PC fields keep their last values.
            r_pc       <= w_redirect_pc;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
        end else if (w_advance) begin
            r_pc          <= w_pc_plus4;
            r_id_valid    <= 1'b1;
            r_id_instr    <= imem_rdata_i;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_plus4;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_advance)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (stall_i && !redirect_i)
                r_perf_stall <= r_perf_stall + 32'd1;
            if (redirect_i)
                r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
    assign perf_flush_o = r_perf_flush;
`else
    assign perf_fetch_o = '0;
    assign perf_stall_o = '0;
    assign perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a reference model pushes expected IF/ID state per step,
// popped and compared after the clock edge.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] pf_fetch;
    logic [31:0] pf_stall;
    logic [31:0] pf_flush;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] idpc;
        logic [31:0] idpc4;
        logic [31:0] c_fetch;
        logic [31:0] c_stall;
        logic [31:0] c_flush;
    } exp_t;

    exp_t m;
    exp_t q[$];

    always #5 clk = ~clk;

    assign imem_rdata = 32'h2000_0000 + {2'b00, imem_addr[31:2]};

    if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redir),
        .redirect_pc_i(redir_pc), .imem_addr_o(imem_addr), .imem_en_o(imem_en),
        .imem_rdata_i(imem_rdata), .id_valid_o(id_valid), .id_instr_o(id_instr),
        .id_pc_o(id_pc), .id_pc_plus4_o(id_pc4), .perf_fetch_o(pf_fetch),
        .perf_stall_o(pf_stall), .perf_flush_o(pf_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef IF_PERF_CNT_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic model_reset();
        m.pc = RST_PC; m.valid = 1'b0; m.instr = NOP; m.idpc = '0; m.idpc4 = '0;
        m.c_fetch = '0; m.c_stall = '0; m.c_flush = '0;
    endtask

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, ".pc"},    imem_addr, e.pc);
        chk({tag, ".valid"}, {31'b0, id_valid}, {31'b0, e.valid});
        chk({tag, ".instr"}, id_instr, e.instr);
        chk({tag, ".idpc"},  id_pc, e.idpc);
        chk({tag, ".idpc4"}, id_pc4, e.idpc4);
        chk({tag, ".pfetch"}, pf_fetch, cnt(e.c_fetch));
        chk({tag, ".pstall"}, pf_stall, cnt(e.c_stall));
        chk({tag, ".pflush"}, pf_flush, cnt(e.c_flush));
    endtask

    // Called just after a negedge: drive, check combinational outputs, clock once, compare.
    task automatic step(input string tag, input logic s, input logic r, input logic [31:0] t);
        exp_t e;
        stall = s; redir = r; redir_pc = t;
        #1;
        chk({tag, ".addr"}, imem_addr, m.pc);
        chk({tag, ".en"}, {31'b0, imem_en}, {31'b0, rst_n & (~s | r)});
        if (r) begin
            m.pc = {t[31:2], 2'b00}; m.valid = 1'b0; m.instr = NOP;
            m.c_flush = m.c_flush + 1;
        end else if (s) begin
            m.c_stall = m.c_stall + 1;
        end else begin
            m.valid = 1'b1; m.instr = 32'h2000_0000 + {2'b00, m.pc[31:2]};
            m.idpc = m.pc; m.idpc4 = m.pc + 32'd4; m.pc = m.pc + 32'd4;
            m.c_fetch = m.c_fetch + 1;
        end
        q.push_back(m);
        @(negedge clk);
        e = q.pop_front();
        check_state(tag, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = '0;
        model_reset();
        #2;
        check_state("reset", m);
        chk("reset.en", {31'b0, imem_en}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) step("seq", 1'b0, 1'b0, '0);
        chk("seq.last_pc", id_pc, 32'h0000_000C);

        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, '0);
        chk("stall.addr_held", imem_addr, 32'h0000_0010);
        step("post_stall0", 1'b0, 1'b0, '0);
        chk("post_stall0.idpc", id_pc, 32'h0000_0010);
        step("post_stall1", 1'b0, 1'b0, '0);
        chk("post_stall1.idpc", id_pc, 32'h0000_0014);

        step("redir43", 1'b0, 1'b1, 32'h0000_0043);
        chk("redir43.pc", imem_addr, 32'h0000_0040);
        step("redir43_tgt", 1'b0, 1'b0, '0);
        chk("redir43_tgt.idpc", id_pc, 32'h0000_0040);

        step("redir_stall", 1'b1, 1'b1, 32'h0000_0080);
        chk("redir_stall.pc", imem_addr, 32'h0000_0080);
        step("redir_stall_tgt", 1'b0, 1'b0, '0);

        step("redir_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, '0);
        chk("wrap.idpc4", id_pc4, 32'h0000_0000);
        chk("wrap.nextaddr", imem_addr, 32'h0000_0000);
        step("wrap_next", 1'b0, 1'b0, '0);

        step("pre_rst_stall0", 1'b1, 1'b0, '0);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst", m);
        chk("async_rst.en", {31'b0, imem_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst0", 1'b0, 1'b0, '0);
        step("after_rst1", 1'b0, 1'b0, '0);
        chk("after_rst1.idpc", id_pc, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
